// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control-unit state encoding, opcodes and condition codes
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;
  localparam logic [4:0] OP_LD     = 5'b00000;
  localparam logic [4:0] OP_ST     = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] BR_OPCODE = 5'b10010;
  // IR[20:19] condition field, evaluated by the CON logic rather than here
  localparam logic [1:0] COND_ZR = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_PL = 2'b10;
  localparam logic [1:0] COND_MI = 2'b11;
  function automatic logic [4:0] opcode_of(input logic [31:0] ir);
    return ir[31:27];
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: width-parameterised saturating incrementer with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= rst ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: fetch and conditional-branch step sequencer around the CON flip-flop
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE    = cpu_ctrl_pkg::BR_OPCODE,
  parameter int         CNT_W        = 16,
  parameter int         MEM_WAIT_MAX = 15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir_in,
  input  logic             mem_ready,
  input  logic             con_in,
  output logic             pc_out,
  output logic             mar_in,
  output logic             inc_pc,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             mem_read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in_en,
  output logic             gra,
  output logic             r_out,
  output logic             con_enable,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             branch_taken,
  output logic             done,
  output logic             not_branch,
  output logic             mem_fault,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] skip_cnt
);
  import cpu_ctrl_pkg::*;
  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
  state_t state;
  logic [WAIT_W-1:0] wait_cnt;
  logic is_br;
  logic first_t1;
  assign is_br    = opcode_of(ir_in) == BR_OPCODE;
  assign first_t1 = state == T1 && wait_cnt == '0;
  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      branch_taken <= 1'b0;
      mem_fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= run ? T0 : IDLE;
        T0: begin
          state    <= T1;
          wait_cnt <= '0;
        end
        T1:
          if (mem_ready) state <= T2;
          else if (wait_cnt == WAIT_LAST) begin
            mem_fault <= 1'b1;
            state     <= HALT;
          end else wait_cnt <= wait_cnt + 1'b1;
        T2: state <= T3;
        T3: begin
          state <= is_br ? T4 : IDLE;
          if (is_br) branch_taken <= con_in;
        end
        T4: state <= T5;
        T5: state <= T6;
        T6: state <= run ? T0 : IDLE;
        default: state <= HALT;
      endcase
    end
  end
  // the PC increment happens once per fetch, however long memory stalls
  assign pc_out     = state == T0 || state == T4;
  assign mar_in     = state == T0;
  assign inc_pc     = state == T0;
  assign z_in       = state == T0 || state == T5;
  assign zlow_out   = first_t1 || state == T6;
  assign pc_in      = first_t1 || (state == T6 && branch_taken);
  assign mem_read   = state == T1;
  assign mdr_in     = state == T1;
  assign mdr_out    = state == T2;
  assign ir_in_en   = state == T2;
  assign gra        = state == T3;
  assign r_out      = state == T3;
  assign con_enable = state == T3;
  assign y_in       = state == T4;
  assign c_out      = state == T5;
  assign alu_add    = state == T5;
  assign done       = state == T6;
  assign not_branch = state == T3 && !is_br;
  sat_counter #(.W(CNT_W)) u_taken (
    .clk(clock),
    .rst(clear),
    .inc(state == T6 && branch_taken),
    .cnt(taken_cnt)
  );
  sat_counter #(.W(CNT_W)) u_skip (
    .clk(clock),
    .rst(clear),
    .inc(state == T6 && !branch_taken),
    .cnt(skip_cnt)
  );
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: scoreboard bench checking per-cycle strobes, counters and fault handling
module tb_branch_sequencer;
  logic clock = 1'b0, clear = 1'b1, run = 1'b0, mem_ready = 1'b0, con_in = 1'b0;
  logic [31:0] ir_in = '0;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in, mdr_out, ir_in_en;
  logic gra, r_out, con_enable, y_in, c_out, alu_add, branch_taken, done, not_branch, mem_fault;
  logic [15:0] taken_cnt, skip_cnt;
  logic s_pc_out, s_mar_in, s_inc_pc, s_z_in, s_zlow_out, s_pc_in, s_mem_read, s_mdr_in, s_mdr_out;
  logic s_ir_in_en, s_gra, s_r_out, s_con_enable, s_y_in, s_c_out, s_alu_add, s_branch_taken;
  logic s_done, s_not_branch, s_mem_fault;
  logic [1:0] s_taken_cnt, s_skip_cnt;
  logic [17:0] obs;
  logic [17:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  int m_taken = 0, m_skip = 0;
  logic m_bt = 1'b0;

  localparam logic [17:0] V_T0  = 18'b1111_0000_00_000_0_00_00;
  localparam logic [17:0] V_T1F = 18'b0000_1111_00_000_0_00_00;
  localparam logic [17:0] V_T1W = 18'b0000_0011_00_000_0_00_00;
  localparam logic [17:0] V_T2  = 18'b0000_0000_11_000_0_00_00;
  localparam logic [17:0] V_T3  = 18'b0000_0000_00_111_0_00_00;
  localparam logic [17:0] V_NB  = 18'b0000_0000_00_000_0_00_01;
  localparam logic [17:0] V_T4  = 18'b1000_0000_00_000_1_00_00;
  localparam logic [17:0] V_T5  = 18'b0001_0000_00_000_0_11_00;
  localparam logic [17:0] V_T6T = 18'b0000_1100_00_000_0_00_10;
  localparam logic [17:0] V_T6N = 18'b0000_1000_00_000_0_00_10;

  assign obs = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in, mdr_out, ir_in_en,
                gra, r_out, con_enable, y_in, c_out, alu_add, done, not_branch};

  always #5 clock = ~clock;

  branch_sequencer #(.CNT_W(16)) dut (
    .clock(clock), .clear(clear), .run(run), .ir_in(ir_in), .mem_ready(mem_ready), .con_in(con_in),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .zlow_out(zlow_out),
    .pc_in(pc_in), .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in_en(ir_in_en),
    .gra(gra), .r_out(r_out), .con_enable(con_enable), .y_in(y_in), .c_out(c_out),
    .alu_add(alu_add), .branch_taken(branch_taken), .done(done), .not_branch(not_branch),
    .mem_fault(mem_fault), .taken_cnt(taken_cnt), .skip_cnt(skip_cnt)
  );

  branch_sequencer #(.CNT_W(2)) dut_sat (
    .clock(clock), .clear(clear), .run(run), .ir_in(ir_in), .mem_ready(mem_ready), .con_in(con_in),
    .pc_out(s_pc_out), .mar_in(s_mar_in), .inc_pc(s_inc_pc), .z_in(s_z_in), .zlow_out(s_zlow_out),
    .pc_in(s_pc_in), .mem_read(s_mem_read), .mdr_in(s_mdr_in), .mdr_out(s_mdr_out),
    .ir_in_en(s_ir_in_en), .gra(s_gra), .r_out(s_r_out), .con_enable(s_con_enable),
    .y_in(s_y_in), .c_out(s_c_out), .alu_add(s_alu_add), .branch_taken(s_branch_taken),
    .done(s_done), .not_branch(s_not_branch), .mem_fault(s_mem_fault),
    .taken_cnt(s_taken_cnt), .skip_cnt(s_skip_cnt)
  );

  function automatic logic in_t1(input logic [17:0] e);
    return e == V_T1F || e == V_T1W;
  endfunction

  task automatic push_instr(input logic br, input logic con, input int nwait, input logic idle);
    exp_q.push_back(V_T0);
    for (int i = 0; i <= nwait; i++) exp_q.push_back(i == 0 ? V_T1F : V_T1W);
    exp_q.push_back(V_T2);
    if (!br) exp_q.push_back(V_T3 | V_NB);
    else begin
      exp_q.push_back(V_T3);
      exp_q.push_back(V_T4);
      exp_q.push_back(V_T5);
      exp_q.push_back(con ? V_T6T : V_T6N);
    end
    if (idle) exp_q.push_back('0);
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b1; mem_ready = 1'b1; con_in = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (obs !== 18'b0) begin n_fail++; $display("FAIL reset strobes: got %b want 0", obs); end
    n_checks++;
    if ({mem_fault, branch_taken} !== 2'b00) begin
      n_fail++; $display("FAIL reset flags: mem_fault=%b branch_taken=%b want 0 0", mem_fault, branch_taken);
    end
    n_checks++;
    if (taken_cnt !== 16'd0 || skip_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset counters: taken=%0d skip=%0d want 0 0", taken_cnt, skip_cnt);
    end
    run = 1'b0; mem_ready = 1'b0; con_in = 1'b0; clear = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs !== 18'b0) begin n_fail++; $display("FAIL reset idle strobes: got %b want 0", obs); end
  endtask

  task automatic test_taken();
    logic [17:0] e;
    int k = 0, done_at = 0;
    ir_in = 32'h9000_0000; con_in = 1'b1; run = 1'b1;
    push_instr(1'b1, 1'b1, 0, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge clock); k++; run = 1'b0;
      e = exp_q.pop_front();
      if (done && done_at == 0) done_at = k;
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL taken cycle %0d: got %b want %b", k, obs, e); end
      mem_ready = in_t1(e) && exp_q.size() > 0 && exp_q[0] !== V_T1W;
    end
    m_taken++; m_bt = 1'b1;
    n_checks++;
    if (done_at != 7) begin n_fail++; $display("FAIL taken done cycle: got %0d want 7", done_at); end
    n_checks++;
    if (branch_taken !== m_bt) begin n_fail++; $display("FAIL taken branch_taken: got %b want %b", branch_taken, m_bt); end
    n_checks++;
    if (taken_cnt !== 16'(m_taken) || skip_cnt !== 16'(m_skip)) begin
      n_fail++; $display("FAIL taken counters: taken=%0d skip=%0d want %0d %0d", taken_cnt, skip_cnt, m_taken, m_skip);
    end
  endtask

  task automatic test_not_taken();
    logic [17:0] e;
    int k = 0, done_at = 0;
    ir_in = 32'h9000_0000; con_in = 1'b0; run = 1'b1;
    push_instr(1'b1, 1'b0, 0, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge clock); k++; run = 1'b0;
      e = exp_q.pop_front();
      if (done && done_at == 0) done_at = k;
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL not_taken cycle %0d: got %b want %b", k, obs, e); end
      mem_ready = in_t1(e) && exp_q.size() > 0 && exp_q[0] !== V_T1W;
    end
    m_skip++; m_bt = 1'b0;
    n_checks++;
    if (done_at != 7) begin n_fail++; $display("FAIL not_taken done cycle: got %0d want 7", done_at); end
    n_checks++;
    if (branch_taken !== m_bt) begin n_fail++; $display("FAIL not_taken branch_taken: got %b want %b", branch_taken, m_bt); end
    n_checks++;
    if (taken_cnt !== 16'(m_taken) || skip_cnt !== 16'(m_skip)) begin
      n_fail++; $display("FAIL not_taken counters: taken=%0d skip=%0d want %0d %0d", taken_cnt, skip_cnt, m_taken, m_skip);
    end
  endtask

  task automatic test_mem_wait();
    logic [17:0] e;
    int k = 0, done_at = 0, n_rd = 0, n_pcin = 0;
    ir_in = 32'h9008_0000; con_in = 1'b1; run = 1'b1;
    push_instr(1'b1, 1'b1, 3, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge clock); k++; run = 1'b0;
      e = exp_q.pop_front();
      if (done && done_at == 0) done_at = k;
      n_rd += int'(mem_read);
      n_pcin += int'(pc_in);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL mem_wait cycle %0d: got %b want %b", k, obs, e); end
      mem_ready = in_t1(e) && exp_q.size() > 0 && exp_q[0] !== V_T1W;
    end
    m_taken++; m_bt = 1'b1;
    n_checks++;
    if (done_at != 10) begin n_fail++; $display("FAIL mem_wait done cycle: got %0d want 10", done_at); end
    n_checks++;
    if (n_rd != 4 || n_pcin != 2) begin
      n_fail++; $display("FAIL mem_wait strobe counts: mem_read=%0d pc_in=%0d want 4 2", n_rd, n_pcin);
    end
    n_checks++;
    if (taken_cnt !== 16'(m_taken) || skip_cnt !== 16'(m_skip)) begin
      n_fail++; $display("FAIL mem_wait counters: taken=%0d skip=%0d want %0d %0d", taken_cnt, skip_cnt, m_taken, m_skip);
    end
  endtask

  task automatic test_non_branch();
    logic [17:0] e;
    int k = 0, nb_cnt = 0;
    ir_in = 32'h1800_0000; con_in = 1'b0; run = 1'b1;
    push_instr(1'b0, 1'b0, 0, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge clock); k++; run = 1'b0;
      e = exp_q.pop_front();
      nb_cnt += int'(not_branch);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL non_branch cycle %0d: got %b want %b", k, obs, e); end
      mem_ready = in_t1(e) && exp_q.size() > 0 && exp_q[0] !== V_T1W;
    end
    n_checks++;
    if (nb_cnt != 1) begin n_fail++; $display("FAIL non_branch pulse count: got %0d want 1", nb_cnt); end
    n_checks++;
    if (branch_taken !== m_bt) begin n_fail++; $display("FAIL non_branch branch_taken: got %b want %b", branch_taken, m_bt); end
    n_checks++;
    if (taken_cnt !== 16'(m_taken) || skip_cnt !== 16'(m_skip)) begin
      n_fail++; $display("FAIL non_branch counters: taken=%0d skip=%0d want %0d %0d", taken_cnt, skip_cnt, m_taken, m_skip);
    end
  endtask

  task automatic test_clear_mid();
    logic [17:0] e;
    int k = 0;
    logic hit = 1'b0;
    ir_in = 32'h9010_0000; con_in = 1'b1; run = 1'b1;
    push_instr(1'b1, 1'b1, 0, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge clock); k++; run = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL clear_mid cycle %0d: got %b want %b", k, obs, e); end
      mem_ready = in_t1(e) && exp_q.size() > 0 && exp_q[0] !== V_T1W;
      if (e == V_T4) begin hit = 1'b1; clear = 1'b1; exp_q.delete(); end
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL clear_mid never reached T4 in %0d cycles", k); end
    @(negedge clock);
    m_taken = 0; m_skip = 0; m_bt = 1'b0;
    n_checks++;
    if (obs !== 18'b0) begin n_fail++; $display("FAIL clear_mid strobes: got %b want 0", obs); end
    n_checks++;
    if ({mem_fault, branch_taken} !== 2'b00 || taken_cnt !== 16'd0 || skip_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clear_mid state: fault=%b bt=%b taken=%0d skip=%0d want all 0", mem_fault, branch_taken, taken_cnt, skip_cnt);
    end
    clear = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs !== 18'b0) begin n_fail++; $display("FAIL clear_mid idle strobes: got %b want 0", obs); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    logic cons [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int k = 0, d = 0;
    for (int i = 0; i < 6; i++) begin
      push_instr(1'b1, cons[i], 0, i == 5);
      if (cons[i]) m_taken++; else m_skip++;
    end
    ir_in = 32'h9018_0000; con_in = cons[0]; run = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clock); k++;
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL back_to_back cycle %0d: got %b want %b", k, obs, e); end
      if (e[1]) d++;
      run = d < 6;
      if (d < 6) con_in = cons[d];
      mem_ready = in_t1(e) && exp_q.size() > 0 && exp_q[0] !== V_T1W;
    end
    m_bt = 1'b1;
    n_checks++;
    if (taken_cnt !== 16'(m_taken) || skip_cnt !== 16'(m_skip)) begin
      n_fail++; $display("FAIL back_to_back counters: taken=%0d skip=%0d want %0d %0d", taken_cnt, skip_cnt, m_taken, m_skip);
    end
    n_checks++;
    if (s_taken_cnt !== 2'd3 || s_skip_cnt !== 2'd1) begin
      n_fail++; $display("FAIL saturation counters: taken=%0d skip=%0d want 3 1", s_taken_cnt, s_skip_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [17:0] e;
    int idx = 0;
    ir_in = 32'h9000_0000; con_in = 1'b1; run = 1'b1; mem_ready = 1'b0;
    exp_q.push_back(V_T0);
    exp_q.push_back(V_T1F);
    for (int i = 0; i < 14; i++) exp_q.push_back(V_T1W);
    for (int i = 0; i < 3; i++) exp_q.push_back('0);
    while (exp_q.size() > 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL timeout cycle %0d: got %b want %b", idx + 1, obs, e); end
      n_checks++;
      if (mem_fault !== (idx >= 16)) begin
        n_fail++; $display("FAIL timeout mem_fault cycle %0d: got %b want %b", idx + 1, mem_fault, idx >= 16);
      end
      if (idx >= 16) mem_ready = 1'b1;
      idx++;
    end
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    m_taken = 0; m_skip = 0; m_bt = 1'b0;
    n_checks++;
    if (mem_fault !== 1'b0 || obs !== 18'b0) begin
      n_fail++; $display("FAIL timeout clear: mem_fault=%b strobes=%b want 0 0", mem_fault, obs);
    end
    clear = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_taken();
    test_not_taken();
    test_mem_wait();
    test_non_branch();
    test_clear_mid();
    test_back_to_back();
    test_timeout();
    test_taken();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Control-unit slice that drives the conditional-branch datapath steps around the CON flip-flop.
- Fetches the instruction (with a memory-ready wait) and drives Gra/Rout/con_enable.
- Samples the CON result, computes PC+C through Y/ALU/Z, and loads the PC only when the condition held.
- Sits in the control unit between the IR/memory interface and the datapath strobes. It counts taken and not-taken branches for debug.

Parameters:
- BR_OPCODE, 5'b10010, IR[31:27] value identifying a conditional branch.
- CNT_W, 16, width of the taken/not-taken statistics counters.
- MEM_WAIT_MAX, 15, maximum cycles to wait for mem_ready before raising mem_fault.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- run  in  1  level; the sequencer leaves IDLE only while run=1.
- ir_in  in  32  IR contents; valid from state T3 onward.
- mem_ready  in  1  memory read done; sampled in T1.
- con_in  in  1  CON flip-flop output; sampled in T3.
- pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mem_read, mdr_in, mdr_out, ir_in_en, gra, r_out, con_enable, y_in, c_out, alu_add  out  1 each  datapath strobes.
- branch_taken  out  1  registered con_in captured in T3.
- done  out  1  one-cycle pulse at the end of each instruction.
- not_branch  out  1  one-cycle pulse when the fetched opcode is not BR_OPCODE.
- mem_fault  out  1  sticky; set on memory timeout.
- taken_cnt  out  CNT_W  count of taken branches.
- skip_cnt  out  CNT_W  count of not-taken branches.

Behaviour:
- Reset (clear=1 at an edge): state=IDLE; all strobes, done, not_branch and mem_fault = 0; branch_taken=0; counters=0; wait counter=0. clear has priority over everything, including mid-instruction.
- Strobes are Moore outputs decoded from the state register. Any strobe not listed below is 0.
- IDLE: no strobes. Go to T0 if run=1.
- T0: pc_out, mar_in, inc_pc, z_in. Go to T1.
- T1: zlow_out, pc_in, mem_read, mdr_in.
  - mem_read stays high while waiting.
  - zlow_out and pc_in are asserted only on the first T1 cycle, so the PC increments once.
  - Leave for T2 on a cycle with mem_ready=1; otherwise increment the wait counter.
  - If the wait counter reaches MEM_WAIT_MAX: set mem_fault and go to HALT.
- T2: mdr_out, ir_in_en. Go to T3.
- T3: gra, r_out, con_enable.
  - Decode ir_in[31:27].
  - If it is not BR_OPCODE: pulse not_branch and go to IDLE; no counter change.
  - Otherwise: branch_taken <= con_in and go to T4.
- T4: pc_out, y_in. Go to T5.
- T5: c_out, alu_add, z_in. Go to T6.
- T6: zlow_out always; pc_in only if branch_taken=1.
  - Increment taken_cnt if taken, else skip_cnt.
  - Pulse done.
  - Go to T0 if run=1, else IDLE.
- HALT: no strobes; exits only via clear.
- Counters saturate at all-ones; they do not wrap.
- run dropping mid-instruction has no effect until T6 completes.
- Condition encoding assumed by CON is IR[20:19]:
  - 00 = zero
  - 01 = nonzero
  - 10 = positive (bit31 = 0 and value != 0)
  - 11 = negative (bit31 = 1)
  - The sequencer never decodes this field itself.
- Latency: 7 cycles IDLE-exit to done with mem_ready=1 on the first T1 cycle. Each wait cycle adds 1.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enumeration (IDLE, T0–T6, HALT), 4-bit encoding;
  - opcode constants including BR_OPCODE;
  - condition-code constants COND_ZR, COND_NZ, COND_PL, COND_MI.
- One sub-module, sat_counter (width-parameterised saturating increment with sync clear), instantiated for taken_cnt and skip_cnt.

Test Plan:
1. Taken branch: run=1, mem_ready=1 on the first T1 cycle, ir_in=0x9000_0000 (BR_OPCODE, cond 00), con_in=1 at T3 -> pc_in high in T1 and T6; done at cycle 7; taken_cnt=1; skip_cnt=0.
2. Not taken: same sequence with con_in=0 -> pc_in absent in T6; branch_taken=0; skip_cnt=1; done still at cycle 7.
3. Memory wait: mem_ready held 0 for 3 T1 cycles -> mem_read high for 4 cycles; pc_in only on the first T1 cycle; done at cycle 10.
4. Timeout: mem_ready never asserted -> mem_fault=1 after 15 wait cycles; HALT with all strobes 0; clear returns to IDLE with mem_fault=0.
5. Non-branch opcode: ir_in=0x1800_0000 -> not_branch pulses at T3; state returns to IDLE; no pc_in in T6 (T6 never reached); counters unchanged.
6. Clear mid-instruction at T4 -> next cycle IDLE, all outputs 0; counter saturation checked with CNT_W=2: 5 taken branches -> taken_cnt=3.
